// File: rtl/jtkcpu_membus.sv
// Byte-wide bus bridge for the CPU: splits 8/16-bit accesses into big-endian
// byte cycles with bus_ok wait states and a per-byte timeout.
module jtkcpu_membus #(
  parameter logic [3:0] WAITMAX = 4'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        req,
  input  logic        wrq,
  input  logic        wide,
  input  logic [15:0] addr,
  input  logic [15:0] dout,
  output logic [15:0] mdata,
  output logic        mem_busy,
  output logic        buserror,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  output logic        bus_cs,
  output logic        bus_we,
  input  logic        bus_ok
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t      state;
  logic [15:0] addr_l;
  logic [15:0] dout_l;
  logic        wrq_l;
  logic        wide_l;
  logic [3:0]  wcnt;
  logic [7:0]  hi_l;

  // Bus side is a pure decode of the held state, so it freezes with cen=0
  // and drops the moment rst rises.
  always_comb begin
    mem_busy = (state == IDLE && req) || state == ACC0 || state == ACC1;
    bus_cs   = 1'b0;
    bus_we   = 1'b0;
    bus_addr = 16'h0000;
    bus_dout = 8'h00;
    case (state)
      ACC0: begin
        bus_cs   = 1'b1;
        bus_we   = wrq_l;
        bus_addr = addr_l;
        bus_dout = wide_l ? dout_l[15:8] : dout_l[7:0];
      end
      ACC1: begin
        bus_cs   = 1'b1;
        bus_we   = wrq_l;
        bus_addr = addr_l + 16'd1;
        bus_dout = dout_l[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_l   <= 16'h0000;
      dout_l   <= 16'h0000;
      wrq_l    <= 1'b0;
      wide_l   <= 1'b0;
      wcnt     <= 4'd0;
      hi_l     <= 8'h00;
      mdata    <= 16'h0000;
      buserror <= 1'b0;
    end else if (cen) begin
      case (state)
        IDLE: begin
          buserror <= 1'b0;
          if (req) begin
            addr_l <= addr;
            dout_l <= dout;
            wrq_l  <= wrq;
            wide_l <= wide;
            wcnt   <= 4'd0;
            state  <= ACC0;
          end
        end
        ACC0: begin
          if (bus_ok) begin
            if (!wrq_l) begin
              if (wide_l) hi_l  <= bus_din;
              else        mdata <= {8'h00, bus_din};
            end
            if (wide_l) begin
              wcnt  <= 4'd0;
              state <= ACC1;
            end else begin
              state <= DONE;
            end
          end else if (wcnt == WAITMAX) begin
            state    <= DONE;
            buserror <= 1'b1;
            if (!wrq_l) mdata <= 16'hFFFF;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        ACC1: begin
          // bus_ok is tested first so a late ready on the last wait cycle still completes
          if (bus_ok) begin
            if (!wrq_l) mdata <= {hi_l, bus_din};
            state <= DONE;
          end else if (wcnt == WAITMAX) begin
            state    <= DONE;
            buserror <= 1'b1;
            if (!wrq_l) mdata <= 16'hFFFF;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        DONE: begin
          buserror <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtkcpu_membus.sv
// Bench for jtkcpu_membus: acts as the byte bus slave with programmable wait
// states and checks bus cycles, read data, busy time and timeouts.
module tb_jtkcpu_membus;

  localparam int WMAX = 15;

  logic        clk = 1'b0;
  logic        rst, cen, req, wrq, wide, bus_ok;
  logic [15:0] addr, dout, mdata, bus_addr;
  logic [7:0]  bus_dout, bus_din;
  logic        mem_busy, buserror, bus_cs, bus_we;

  logic [7:0]  mem [0:65535];
  logic [15:0] exp_mdata;
  int n_checks = 0;
  int n_pass   = 0;

  jtkcpu_membus #(.WAITMAX(4'd15)) dut (
    .clk(clk), .rst(rst), .cen(cen), .req(req), .wrq(wrq), .wide(wide),
    .addr(addr), .dout(dout), .mdata(mdata), .mem_busy(mem_busy),
    .buserror(buserror), .bus_addr(bus_addr), .bus_dout(bus_dout),
    .bus_din(bus_din), .bus_cs(bus_cs), .bus_we(bus_we), .bus_ok(bus_ok)
  );

  always #5 clk = ~clk;

  // One complete access. w0/w1 are the bus_ok-low cycles the slave inserts
  // before each byte; anything above WMAX means the byte never completes.
  task automatic run_access(input string nm, input logic w, input logic wd,
                            input logic [15:0] a, input logic [15:0] d,
                            input int w0, input int w1, input bit gated);
    logic [15:0] a1;
    logic [15:0] ea [2];
    logic [7:0]  ed [2];
    int n_exp, exp_busy, cyc, busy, waits, nb, tgt;
    logic exp_err;
    bit accepted, done;
    a1 = a + 16'd1;
    ea[0] = a;  ea[1] = a1;
    ed[0] = wd ? d[15:8] : d[7:0];
    ed[1] = d[7:0];
    exp_busy = 1; exp_err = 1'b0; n_exp = 0;
    if (w0 > WMAX) begin
      exp_busy += WMAX + 1; exp_err = 1'b1;
    end else begin
      exp_busy += w0 + 1; n_exp = 1;
      if (wd) begin
        if (w1 > WMAX) begin exp_busy += WMAX + 1; exp_err = 1'b1; end
        else begin exp_busy += w1 + 1; n_exp = 2; end
      end
    end
    if (!w) begin
      if (exp_err)  exp_mdata = 16'hFFFF;
      else if (wd)  exp_mdata = {mem[a], mem[a1]};
      else          exp_mdata = {8'h00, mem[a]};
    end

    cyc = 0; busy = 0; waits = 0; nb = 0; accepted = 0; done = 0;
    @(negedge clk);
    req = 1'b1; wrq = w; wide = wd; addr = a; dout = d;
    while (!done && cyc < 300) begin
      if (cyc > 0) @(negedge clk);
      cen = gated ? (cyc % 3 == 2) : 1'b1;
      if (accepted) begin
        req = 1'b0; addr = 16'($urandom); dout = 16'($urandom);
        wrq = 1'($urandom); wide = 1'($urandom);
      end
      tgt = (nb == 0) ? w0 : w1;
      bus_ok = (waits >= tgt);
      #1;
      bus_din = mem[bus_addr];
      if (cen) begin
        if (mem_busy) busy++;
        if (accepted && !mem_busy) begin
          done = 1;
          n_checks++;
          if (buserror !== exp_err) $display("FAIL %s buserror: got %b expected %b", nm, buserror, exp_err);
          else n_pass++;
          n_checks++;
          if (mdata !== exp_mdata) $display("FAIL %s mdata: got %h expected %h", nm, mdata, exp_mdata);
          else n_pass++;
        end
        if (bus_cs) begin
          if (bus_ok) begin
            if (nb >= n_exp) begin
              n_checks++;
              $display("FAIL %s extra_xfer: got transfer %0d at %h, expected %0d transfers", nm, nb + 1, bus_addr, n_exp);
            end else begin
              n_checks++;
              if (bus_addr !== ea[nb]) $display("FAIL %s bus_addr[%0d]: got %h expected %h", nm, nb, bus_addr, ea[nb]);
              else n_pass++;
              n_checks++;
              if (bus_we !== w) $display("FAIL %s bus_we[%0d]: got %b expected %b", nm, nb, bus_we, w);
              else n_pass++;
              if (w) begin
                n_checks++;
                if (bus_dout !== ed[nb]) $display("FAIL %s bus_dout[%0d]: got %h expected %h", nm, nb, bus_dout, ed[nb]);
                else n_pass++;
                mem[bus_addr] = bus_dout;
              end
            end
            nb++; waits = 0;
          end else begin
            waits++;
          end
        end
        if (!accepted && mem_busy) accepted = 1;
      end
      cyc++;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL %s done_timeout: got no DONE after %0d cycles, expected one", nm, cyc);
    end
    n_checks++;
    if (busy !== exp_busy) $display("FAIL %s busy_cycles: got %0d expected %0d", nm, busy, exp_busy);
    else n_pass++;
    n_checks++;
    if (nb !== n_exp) $display("FAIL %s xfer_count: got %0d expected %0d", nm, nb, n_exp);
    else n_pass++;
    @(negedge clk);
    cen = 1'b1; bus_ok = 1'b0;
    #1;
    n_checks++;
    if (buserror !== 1'b0 || mem_busy !== 1'b0)
      $display("FAIL %s after_done: got buserror=%b mem_busy=%b expected 0/0", nm, buserror, mem_busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0; cen = 1'b0; req = 1'b0; wrq = 1'b0; wide = 1'b0;
    addr = 16'h0; dout = 16'h0; bus_ok = 1'b0; bus_din = 8'h0;
    #1 rst = 1'b1;
    #2;
    n_checks++;
    if ({mdata, bus_addr, bus_dout, bus_cs, bus_we, buserror, mem_busy} !== 44'h0)
      $display("FAIL reset_state: got mdata=%h addr=%h dout=%h cs=%b we=%b err=%b busy=%b expected all 0",
               mdata, bus_addr, bus_dout, bus_cs, bus_we, buserror, mem_busy);
    else n_pass++;
    exp_mdata = 16'h0000;
    @(negedge clk); rst = 1'b0; cen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (bus_cs !== 1'b0 || mem_busy !== 1'b0) $display("FAIL idle_after_reset: got cs=%b busy=%b expected 0/0", bus_cs, mem_busy);
      else n_pass++;
    end
    // A request seen only on a cen=0 edge must not be taken.
    @(negedge clk); cen = 1'b0; req = 1'b1;
    @(negedge clk); cen = 1'b1; req = 1'b0; #1;
    n_checks++;
    if (mem_busy !== 1'b0 || bus_cs !== 1'b0) $display("FAIL no_accept_cen0: got busy=%b cs=%b expected 0/0", mem_busy, bus_cs);
    else n_pass++;
  endtask

  task automatic test_read8();
    mem[16'h1234] = 8'hA5;
    run_access("read8", 1'b0, 1'b0, 16'h1234, 16'h0, 0, 0, 1'b0);
    n_checks++;
    if (exp_mdata !== 16'h00A5) $display("FAIL read8_model: got %h expected 00a5", exp_mdata);
    else n_pass++;
  endtask

  task automatic test_write16_wrap();
    run_access("write16_wrap", 1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 0, 0, 1'b0);
  endtask

  task automatic test_wait_states();
    mem[16'h3000] = 8'h12; mem[16'h3001] = 8'h34;
    run_access("wait_states", 1'b0, 1'b1, 16'h3000, 16'h0, 3, 3, 1'b0);
    run_access("wait_boundary", 1'b0, 1'b1, 16'h3000, 16'h0, WMAX, WMAX, 1'b0);
  endtask

  task automatic test_timeout();
    run_access("timeout_read8", 1'b0, 1'b0, 16'h5555, 16'h0, 100, 0, 1'b0);
    run_access("timeout_wr16_b1", 1'b1, 1'b1, 16'h6000, 16'hCAFE, 1, 100, 1'b0);
    run_access("timeout_rd16_b1", 1'b0, 1'b1, 16'h6100, 16'h0, 0, WMAX + 1, 1'b0);
  endtask

  task automatic test_reset_acc1();
    @(negedge clk);
    req = 1'b1; wrq = 1'b0; wide = 1'b1; addr = 16'h4321; cen = 1'b1; bus_ok = 1'b1;
    @(negedge clk); req = 1'b0; #1 bus_din = mem[bus_addr];
    @(negedge clk); bus_ok = 1'b0; #1;
    n_checks++;
    if (bus_cs !== 1'b1 || bus_addr !== 16'h4322) $display("FAIL acc1_reached: got cs=%b addr=%h expected 1/4322", bus_cs, bus_addr);
    else n_pass++;
    rst = 1'b1; #1;
    n_checks++;
    if ({bus_cs, bus_we, mem_busy, buserror, mdata, bus_addr} !== 36'h0)
      $display("FAIL reset_in_acc1: got cs=%b we=%b busy=%b err=%b mdata=%h addr=%h expected all 0",
               bus_cs, bus_we, mem_busy, buserror, mdata, bus_addr);
    else n_pass++;
    exp_mdata = 16'h0000;
    @(negedge clk); rst = 1'b0;
    mem[16'h4321] = 8'h9C; mem[16'h4322] = 8'h3D;
    run_access("after_reset", 1'b0, 1'b1, 16'h4321, 16'h0, 0, 1, 1'b0);
  endtask

  task automatic test_cen_gating();
    mem[16'h1234] = 8'hA5;
    run_access("gated_read8", 1'b0, 1'b0, 16'h1234, 16'h0, 0, 0, 1'b1);
    run_access("gated_write16", 1'b1, 1'b1, 16'hFFFF, 16'h1357, 0, 0, 1'b1);
    mem[16'h3000] = 8'h12; mem[16'h3001] = 8'h34;
    run_access("gated_waits", 1'b0, 1'b1, 16'h3000, 16'h0, 3, 3, 1'b1);
    run_access("gated_timeout", 1'b0, 1'b0, 16'h7777, 16'h0, 50, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic exp_bz [6];
    logic exp_cs [6];
    logic [15:0] m0, m1;
    exp_bz = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_cs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    mem[16'h2000] = 8'h5A; mem[16'h2001] = 8'hC3;
    m0 = {8'h00, mem[16'h2000]};
    m1 = {8'h00, mem[16'h2001]};
    @(negedge clk);
    req = 1'b1; wrq = 1'b0; wide = 1'b0; addr = 16'h2000; cen = 1'b1; bus_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 2) addr = 16'h2001;
      if (i == 5) req = 1'b0;
      #1;
      bus_din = mem[bus_addr];
      n_checks++;
      if (mem_busy !== exp_bz[i] || bus_cs !== exp_cs[i])
        $display("FAIL b2b_cycle%0d: got busy=%b cs=%b expected %b/%b", i, mem_busy, bus_cs, exp_bz[i], exp_cs[i]);
      else n_pass++;
      if (i == 2 || i == 5) begin
        n_checks++;
        if (mdata !== (i == 2 ? m0 : m1)) $display("FAIL b2b_mdata%0d: got %h expected %h", i, mdata, (i == 2 ? m0 : m1));
        else n_pass++;
      end
      if (i == 4) begin
        n_checks++;
        if (bus_addr !== 16'h2001) $display("FAIL b2b_addr: got %h expected 2001", bus_addr);
        else n_pass++;
      end
    end
    exp_mdata = m1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic w, wd;
      logic [15:0] a, d;
      int w0, w1;
      w  = 1'($urandom);
      wd = 1'($urandom);
      a  = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
      d  = 16'($urandom);
      w0 = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
      w1 = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
      run_access($sformatf("random%0d", i), w, wd, a, d, w0, w1, 1'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_read8();
    test_write16_wrap();
    test_wait_states();
    test_timeout();
    test_back_to_back();
    test_reset_acc1();
    test_cen_gating();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
